entropy_bitstream_packer: RTL and testbench

//  Packs the variable-length codewords from the AC level entropy encoder into MSB-first 32-bit words.

---
 rtl/entropy_bitstream_packer_pkg.sv | 27 ++
 rtl/entropy_bitstream_packer_if.sv | 32 +++
 rtl/entropy_bitstream_packer_acc_shifter.sv | 36 +++
 rtl/entropy_bitstream_packer.sv | 138 +++++++++++++
 tb/tb_entropy_bitstream_packer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/entropy_bitstream_packer_pkg.sv
// Shared constants, FSM state type and helpers for the entropy bitstream packer.
package entropy_pkg;

  localparam int unsigned OUT_WIDTH    = 32;
  localparam int unsigned MAX_CODE_LEN = 32;
  localparam int unsigned CNT_WIDTH    = 32;
  localparam int unsigned ACC_WIDTH    = 2 * OUT_WIDTH;
  localparam int unsigned LEN_WIDTH    = 6;
  localparam int unsigned FILL_WIDTH   = $clog2(ACC_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Low-bit mask covering 'len' bits; len >= OUT_WIDTH gives all ones.
  function automatic logic [OUT_WIDTH-1:0] len_mask(input logic [LEN_WIDTH-1:0] len);
    logic [OUT_WIDTH-1:0] m;
    m = '1;
    if (len < LEN_WIDTH'(OUT_WIDTH)) begin
      m = ~(m << len);
    end
    return m;
  endfunction

endpackage

// File: rtl/entropy_bitstream_packer_if.sv
// Codeword input stream, packed word output stream and segment status.
interface entropy_bitstream_packer_if import entropy_pkg::*; ();

  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_WIDTH-1:0]  in_code;
  logic [LEN_WIDTH-1:0]  in_length;
  logic                  in_flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_last;
  logic [LEN_WIDTH-1:0]  out_bits;
  logic [CNT_WIDTH-1:0]  total_bits;
  logic                  flush_done;
  logic                  len_err;

  // Producer of codewords / consumer of packed words.
  modport master (
    output in_valid, in_code, in_length, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_bits,
           total_bits, flush_done, len_err
  );

  // The packer itself.
  modport slave (
    input  in_valid, in_code, in_length, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_last, out_bits,
           total_bits, flush_done, len_err
  );

endinterface

// File: rtl/entropy_bitstream_packer_acc_shifter.sv
// Combinational next-state for the 64-bit MSB-first accumulator and its fill count.
module bitstream_acc_shifter import entropy_pkg::*; (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [FILL_WIDTH-1:0] fill_i,
  input  logic [OUT_WIDTH-1:0]  code_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  append_i,
  input  logic                  drain_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic [FILL_WIDTH-1:0] fill_o
);

  logic [ACC_WIDTH-1:0]  base_acc;
  logic [FILL_WIDTH-1:0] base_fill;
  logic [FILL_WIDTH-1:0] shamt;
  logic [ACC_WIDTH-1:0]  placed;

  // Drain first, then append at the post-drain position so the codeword MSB lands at bit 63-fill.
  always_comb begin
    base_acc  = acc_i;
    base_fill = fill_i;
    if (drain_i) begin
      base_acc  = acc_i << OUT_WIDTH;
      base_fill = fill_i - FILL_WIDTH'(OUT_WIDTH);
    end
    shamt  = FILL_WIDTH'(ACC_WIDTH) - base_fill - FILL_WIDTH'(len_i);
    placed = ACC_WIDTH'(code_i & len_mask(len_i)) << shamt;
    acc_o  = base_acc;
    fill_o = base_fill;
    if (append_i) begin
      acc_o  = base_acc | placed;
      fill_o = base_fill + FILL_WIDTH'(len_i);
    end
  end

endmodule

// File: rtl/entropy_bitstream_packer.sv
// Packs variable-length codewords MSB-first into 32-bit words, with flush/pad and bit counting.
module entropy_bitstream_packer import entropy_pkg::*; (
  input  logic                        clk,
  input  logic                        reset,
  entropy_bitstream_packer_if.slave   bus
);

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_shift;
  logic [FILL_WIDTH-1:0] fill_q, fill_d, fill_shift;
  logic [OUT_WIDTH-1:0]  out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [LEN_WIDTH-1:0]  out_bits_q;
  logic [CNT_WIDTH-1:0]  total_q;
  logic                  flush_done_q;
  logic                  len_err_q;

  logic                  in_ready;
  logic                  accept;
  logic                  reg_free;
  logic                  full_word;
  logic                  len_over;
  logic [LEN_WIDTH-1:0]  len_c;
  logic                  drain;
  logic                  load_pad;
  logic                  clear;

  assign len_over  = bus.in_length > LEN_WIDTH'(MAX_CODE_LEN);
  assign len_c     = len_over ? LEN_WIDTH'(MAX_CODE_LEN) : bus.in_length;
  assign in_ready  = (state_q == ST_RUN) && (fill_q <= FILL_WIDTH'(OUT_WIDTH));
  assign accept    = bus.in_valid && in_ready;
  assign reg_free  = !out_valid_q || bus.out_ready;
  assign full_word = fill_q >= FILL_WIDTH'(OUT_WIDTH);

  // FSM next state plus drain/pad/clear decisions for this cycle.
  always_comb begin
    state_d  = state_q;
    drain    = 1'b0;
    load_pad = 1'b0;
    clear    = 1'b0;
    case (state_q)
      ST_RUN: begin
        drain = full_word && reg_free;
        if (accept && bus.in_flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (full_word) begin
          drain = reg_free;
        end else if (fill_q != '0) begin
          if (reg_free) begin
            load_pad = 1'b1;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (reg_free) begin
          clear   = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  bitstream_acc_shifter u_shifter (
    .acc_i    (acc_q),
    .fill_i   (fill_q),
    .code_i   (bus.in_code),
    .len_i    (len_c),
    .append_i (accept),
    .drain_i  (drain),
    .acc_o    (acc_shift),
    .fill_o   (fill_shift)
  );

  assign acc_d  = clear ? '0 : acc_shift;
  assign fill_d = clear ? '0 : fill_shift;

  // State, accumulator, output register, bit counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_bits_q   <= '0;
      total_q      <= '0;
      flush_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= clear;
      if (accept) begin
        total_q <= total_q + CNT_WIDTH'(len_c);
        if (len_over) begin
          len_err_q <= 1'b1;
        end
      end else if (clear) begin
        total_q <= '0;
      end
      if (drain) begin
        out_data_q  <= acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
        out_bits_q  <= LEN_WIDTH'(OUT_WIDTH);
      end else if (load_pad) begin
        // Bits below fill are always zero, so the top half is already padded.
        out_data_q  <= acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b1;
        out_bits_q  <= fill_q[LEN_WIDTH-1:0];
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_bits   = out_bits_q;
  assign bus.total_bits = total_q;
  assign bus.flush_done = flush_done_q;
  assign bus.len_err    = len_err_q;

endmodule

// File: tb/tb_entropy_bitstream_packer.sv
// Directed self-checking bench for entropy_bitstream_packer.
module tb_entropy_bitstream_packer;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  entropy_bitstream_packer_if bus ();

  entropy_bitstream_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] c, input logic [5:0] l, input logic f);
    int unsigned k;
    k = 0;
    bus.in_valid  = 1'b1;
    bus.in_code   = c;
    bus.in_length = l;
    bus.in_flush  = f;
    while (!bus.in_ready && k < 50) begin
      step();
      k++;
    end
    check("send_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic last, input logic [5:0] bits);
    int unsigned k;
    k = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && k < 50) begin
      step();
      k++;
    end
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check({tag, "_data"},  {32'd0, bus.out_data},  {32'd0, d});
    check({tag, "_last"},  {63'd0, bus.out_last},  {63'd0, last});
    check({tag, "_bits"},  {58'd0, bus.out_bits},  {58'd0, bits});
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_flush_done(input string tag);
    int unsigned k;
    k = 0;
    while (!bus.flush_done && k < 20) begin
      step();
      k++;
    end
    check(tag, {63'd0, bus.flush_done}, 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_length = '0;
    bus.in_flush  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid",  {63'd0, bus.out_valid},  64'd0);
    check("rst_out_data",   {32'd0, bus.out_data},   64'd0);
    check("rst_out_last",   {63'd0, bus.out_last},   64'd0);
    check("rst_out_bits",   {58'd0, bus.out_bits},   64'd0);
    check("rst_total",      {32'd0, bus.total_bits}, 64'd0);
    check("rst_flush_done", {63'd0, bus.flush_done}, 64'd0);
    check("rst_len_err",    {63'd0, bus.len_err},    64'd0);
    check("rst_in_ready",   {63'd0, bus.in_ready},   64'd1);

    // Sixteen 2-bit "10" beats form exactly one word; flush on a zero-length beat
    for (int i = 0; i < 16; i++) begin
      send(32'h2, 6'd2, 1'b0);
    end
    check("aa_latency_pre", {63'd0, bus.out_valid}, 64'd0);
    send(32'h0, 6'd0, 1'b1);
    check("aa_latency_post", {63'd0, bus.out_valid}, 64'd1);
    check("aa_total", {32'd0, bus.total_bits}, 64'd32);
    expect_word("aa_word", 32'hAAAAAAAA, 1'b0, 6'd32);
    wait_flush_done("aa_flush_done");
    check("aa_no_last_valid", {63'd0, bus.out_valid}, 64'd0);
    check("aa_no_last",       {63'd0, bus.out_last},  64'd0);
    check("aa_total_clr",     {32'd0, bus.total_bits}, 64'd0);
    step();
    check("aa_pulse_end", {63'd0, bus.flush_done}, 64'd0);

    // 101 + seventeen 1s + 11 = 22 bits, padded: 1011_1111_1111_1111_1111_1100_0000_0000
    send(32'h5, 6'd3, 1'b0);
    send(32'h1FFFF, 6'd17, 1'b0);
    send(32'h3, 6'd2, 1'b1);
    check("pad_total", {32'd0, bus.total_bits}, 64'd22);
    expect_word("pad_word", 32'hBFFFFC00, 1'b1, 6'd22);
    wait_flush_done("pad_flush_done");
    check("pad_last_clr", {63'd0, bus.out_last}, 64'd0);

    // Upper code bits beyond the length are ignored
    send(32'hFFFFFFFF, 6'd4, 1'b1);
    expect_word("mask_word", 32'hF0000000, 1'b1, 6'd4);
    wait_flush_done("mask_flush_done");

    // Backpressure: three full words buffered, the fourth beat is refused
    bus.in_valid  = 1'b1;
    bus.in_code   = 32'hFFFFFFFF;
    bus.in_length = 6'd32;
    bus.in_flush  = 1'b0;
    check("bp_rdy1", {63'd0, bus.in_ready}, 64'd1);
    step();
    check("bp_rdy2", {63'd0, bus.in_ready}, 64'd1);
    step();
    check("bp_rdy3", {63'd0, bus.in_ready}, 64'd1);
    step();
    check("bp_rdy_drop",  {63'd0, bus.in_ready},  64'd0);
    check("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
    check("bp_hold_data", {32'd0, bus.out_data},  64'hFFFFFFFF);
    step();
    step();
    check("bp_rdy_still", {63'd0, bus.in_ready},  64'd0);
    check("bp_total",     {32'd0, bus.total_bits}, 64'd96);
    bus.in_valid = 1'b0;
    expect_word("bp_w1", 32'hFFFFFFFF, 1'b0, 6'd32);
    expect_word("bp_w2", 32'hFFFFFFFF, 1'b0, 6'd32);
    expect_word("bp_w3", 32'hFFFFFFFF, 1'b0, 6'd32);
    bus.out_ready = 1'b1;
    step();
    check("bp_no_dup", {63'd0, bus.out_valid}, 64'd0);
    bus.out_ready = 1'b0;
    send(32'h0, 6'd0, 1'b1);
    wait_flush_done("bp_flush_done");

    // Over-long length clamps to 32 and sets the sticky error
    send(32'h12345678, 6'd40, 1'b1);
    check("len_err_set", {63'd0, bus.len_err},    64'd1);
    check("len_total",   {32'd0, bus.total_bits}, 64'd32);
    expect_word("len_word", 32'h12345678, 1'b0, 6'd32);
    wait_flush_done("len_flush_done");
    check("len_err_sticky", {63'd0, bus.len_err}, 64'd1);

    // Reset while FLUSH is stalled on a held output word
    send(32'hFFFFFFFF, 6'd32, 1'b0);
    send(32'hAB, 6'd8, 1'b1);
    step();
    check("mid_stalled", {63'd0, bus.out_valid}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_out_valid", {63'd0, bus.out_valid},  64'd0);
    check("mid_out_last",  {63'd0, bus.out_last},   64'd0);
    check("mid_total",     {32'd0, bus.total_bits}, 64'd0);
    check("mid_len_err",   {63'd0, bus.len_err},    64'd0);
    check("mid_in_ready",  {63'd0, bus.in_ready},   64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_done",  {63'd0, bus.flush_done}, 64'd0);
      check("mid_no_word",  {63'd0, bus.out_valid},  64'd0);
    end
    bus.out_ready = 1'b0;
    send(32'h3, 6'd2, 1'b1);
    expect_word("mid_fresh", 32'hC0000000, 1'b1, 6'd2);
    wait_flush_done("mid_flush_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
